bin2bcd_seq: RTL

//   Sequential binary-to-BCD converter (shift-and-add-3, "double dabble") sitting

---
 rtl/bin2bcd_seq_pkg.sv | 14 +
 rtl/bin2bcd_seq_bcd_add3.sv | 11 +
 rtl/bin2bcd_seq.sv | 81 ++++++++
 3 files changed

// File: rtl/bin2bcd_seq_pkg.sv
// rtl/bin2bcd_seq_pkg.sv - shared constants and state encoding for bin2bcd_seq
package bin2bcd_seq_pkg;

    localparam int DEF_W   = 20;
    localparam int DEF_D   = 7;
    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OP   = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/bin2bcd_seq_bcd_add3.sv
// rtl/bin2bcd_seq_bcd_add3.sv - combinational "if digit >= 5 add 3" correction cell
module bcd_add3
    import bin2bcd_seq_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [DIGIT_W-1:0] fixed
);

    assign fixed = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential shift-and-add-3 binary to packed BCD converter
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int D = DEF_D
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [W-1:0]         bin,
    output logic                 ready,
    output logic                 done,
    output logic [DIGIT_W*D-1:0] bcd
);

    localparam int CW = $clog2(W + 1);

    state_t                 state, state_next;
    logic [W-1:0]           shift_reg, shift_next;
    logic [DIGIT_W*D-1:0]   acc, acc_next, acc_fixed;
    logic [CW-1:0]          count, count_next;

    for (genvar i = 0; i < D; i++) begin : g_digit
        bcd_add3 u_add3 (
            .digit (acc[DIGIT_W*i +: DIGIT_W]),
            .fixed (acc_fixed[DIGIT_W*i +: DIGIT_W])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            acc       <= '0;
            count     <= '0;
        end else begin
            state     <= state_next;
            shift_reg <= shift_next;
            acc       <= acc_next;
            count     <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        shift_next = shift_reg;
        acc_next   = acc;
        count_next = count;
        ready      = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_next = OP;
                    shift_next = bin;
                    acc_next   = '0;
                    count_next = CW'(W);
                end
            end
            OP: begin
                // The D constraint guarantees the corrected MSB shifted out is always 0.
                acc_next   = (acc_fixed << 1) | {{(DIGIT_W*D-1){1'b0}}, shift_reg[W-1]};
                shift_next = shift_reg << 1;
                count_next = count - 1'b1;
                if (count == CW'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bcd = acc;

endmodule
